miriscv_data_ram_resp: RTL and testbench
========================================

MIRISCV_DATA_RAM_RESP -- requirements
Module: miriscv_data_ram_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from acceptance to the data_rvalid_o pulse (legal 1..4).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 arstn_i  input  1  reset, asynchronous and active-low.
REQ-006 data_req_i  input  1  initiator request; held high with all fields stable until data_rvalid_o.
REQ-007 data_we_i  input  1  1 = write, 0 = read.
REQ-008 data_be_i  input  4  byte enables; bit n selects data bits [8n+7:8n].
REQ-009 data_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-010 data_wdata_i  input  32  write data, already lane-aligned by the initiator.
REQ-011 data_rvalid_o  output  1  one-cycle completion pulse for reads and writes.
REQ-012 data_rdata_o  output  32  read data, valid only while data_rvalid_o = 1.
REQ-013 data_err_o  output  1  out-of-range flag, qualified by data_rvalid_o.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE + data_req_i = 1: SHALL accept, capture we/be/addr/wdata, go to WAIT if LATENCY > 1, else RESP.
REQ-016 WAIT: SHALL decrement a latency counter loaded with LATENCY-1 at acceptance, and go to RESP after LATENCY-1 cycles in WAIT.
REQ-017 RESP: SHALL drive data_rvalid_o = 1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 data_req_i in WAIT or RESP SHALL be ignored; the held request is never accepted twice.
REQ-019 In the IDLE cycle following RESP, data_req_i = 1 SHALL be treated as a new request (back-to-back, one transaction per LATENCY+1 cycles).
REQ-020 Deassertion of data_req_i after acceptance SHALL NOT abort the transaction; the rvalid pulse still occurs.
REQ-021 Index = (addr - BASE_ADDR) >> 2, 32-bit wrap-around subtraction; in range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-022 An in-range write SHALL update only the bytes with be = 1, on the acceptance edge; data_be_i = 0 SHALL leave memory unchanged but still complete.
REQ-023 An in-range read SHALL sample the word on the acceptance edge and present it unmodified (all 4 bytes, regardless of be) in RESP.
REQ-024 A read accepted immediately after a write to the same word SHALL return the written data.
REQ-025 Out of range: writes SHALL be dropped, reads SHALL return 32'h0, and data_err_o = 1 in the RESP cycle.
REQ-026 data_rdata_o SHALL be 32'h0 whenever data_rvalid_o = 0, and for write completions.
REQ-027 data_err_o SHALL be 0 whenever data_rvalid_o = 0.

Reset
REQ-028 arstn_i = 0 SHALL force IDLE, counter = 0, data_rvalid_o = 0, data_rdata_o = 0 and data_err_o = 0 immediately.
REQ-029 Reset mid-transaction SHALL discard the transaction with no rvalid pulse; a write already performed at acceptance remains in memory.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 The first request SHALL be accepted on the first rising edge with arstn_i = 1 and data_req_i = 1.

Verification
REQ-032 LATENCY=1: write addr 0x10, be 4'hF, wdata 0xDEADBEEF, then read 0x10 -> rvalid 1 cycle after each acceptance; rdata = 0xDEADBEEF, err 0.
REQ-033 Byte-enable merge: write 0xFFFFFFFF to 0x20, then write 0x00AB0000 with be 4'b0100, then read 0x20 -> 0xFFABFFFF.
REQ-034 LATENCY=3: read held with req high for 6 cycles -> exactly one rvalid, 3 cycles after acceptance; no second acceptance in WAIT/RESP; next acceptance at the following IDLE cycle.
REQ-035 Out of range: read at BASE_ADDR + DEPTH_WORDS*4 -> rdata 0, err 1 with rvalid. Write to BASE_ADDR-4 -> memory unchanged, err 1.
REQ-036 Reset during WAIT (LATENCY=4) -> rvalid/rdata/err 0 immediately; no later rvalid; next request completes normally.
REQ-037 Back-to-back stream: 8 alternating writes and reads with req continuously high and fields changing the cycle after rvalid -> 8 rvalid pulses with correct data in order.

Source files
------------

// File: rtl/miriscv_data_ram_resp.sv
// Word-addressed data RAM slave with byte enables, out-of-range error flag and a fixed response delay.
// Latency: data_rvalid_o pulses LATENCY cycles after the accepting edge; one transaction per LATENCY+1 cycles.
// Backpressure: none; the initiator holds data_req_i until data_rvalid_o, and requests are ignored while busy.
module miriscv_data_ram_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;

    // Response attributes captured at acceptance
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        unused_addr_lsb;

    logic [31:0] mem [DEPTH_WORDS];

    // Accept only from IDLE and never while reset is asserted, so a held request is taken exactly once
    assign accept   = arstn_i && (state_q == IDLE) && data_req_i;

    // Wrap-around subtraction: addresses below BASE_ADDR produce a huge offset, also caught by the >= test
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = (data_addr_i >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
    assign idx      = offset[AW+1:2];

    // Byte-offset bits carry no meaning for a word-organised memory
    assign unused_addr_lsb = ^{data_addr_i[1:0], offset[1:0]};

    // State and latency-counter registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT for LATENCY-1 cycles) -> RESP for one cycle -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = 3'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                    cnt_d   = 3'd0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Capture response kind, error and read data on the accepting edge
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= data_we_i;
            err_q   <= !in_range;
            rdata_q <= (!data_we_i && in_range) ? mem[idx] : 32'h0;
        end
    end

    // Byte-masked write on the accepting edge; storage is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Outputs are gated by RESP so they clear asynchronously with reset and read as zero when idle
    assign data_rvalid_o = (state_q == RESP);
    assign data_rdata_o  = (data_rvalid_o && !we_q) ? rdata_q : 32'h0;
    assign data_err_o    = data_rvalid_o && err_q;

endmodule

// File: tb/tb_miriscv_data_ram_resp.sv
// Testbench: three instances (LATENCY 1/3/4) checked against an array-based memory model.
// Directed steps first, then random traffic on every instance.
// Outputs sampled on the falling edge; inputs driven just after the rising edge or at the falling edge.
module tb_miriscv_data_ram_resp;

    localparam int DEPTH = 16;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'h0000_0100;
    endfunction

    logic        clk;
    logic        arstn;
    logic        req    [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    logic [31:0] model [3][DEPTH];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        miriscv_data_ram_resp #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (lat_of(g)),
            .BASE_ADDR   (base_of(g))
        ) u_dut (
            .clk_i         (clk),
            .arstn_i       (arstn),
            .data_req_i    (req[g]),
            .data_we_i     (we[g]),
            .data_be_i     (be[g]),
            .data_addr_i   (addr[g]),
            .data_wdata_i  (wdata[g]),
            .data_rvalid_o (rvalid[g]),
            .data_rdata_o  (rdata[g]),
            .data_err_o    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic in_rng(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(k);
        return (a >= base_of(k)) && ((off >> 2) < 32'(DEPTH));
    endfunction

    function automatic int widx(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(k);
        return int'(off[5:2]);
    endfunction

    // One complete transaction: model update, drive, latency/data/error checks, pulse-width check
    task automatic txn(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic keep, output logic [31:0] got);
        logic        inr;
        logic [31:0] er;
        int          n;
        inr = in_rng(k, a);
        er  = (!w && inr) ? model[k][widx(k, a)] : 32'h0;
        if (w && inr) model[k][widx(k, a)] = merge(model[k][widx(k, a)], d, b);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rvalid[k]) begin
                chk("quiet_rdata", rdata[k], 32'h0);
                chk("quiet_err", {31'h0, err[k]}, 32'h0);
            end
        end while (!rvalid[k] && n < 8);
        got = rdata[k];
        chk($sformatf("latency_i%0d", k), 32'(n), 32'(lat_of(k)));
        chk($sformatf("rdata_i%0d_a%h", k, a), rdata[k], er);
        chk($sformatf("err_i%0d_a%h", k, a), {31'h0, err[k]}, {31'h0, !inr});
        @(posedge clk);
        #1;
        req[k] = keep;
        @(negedge clk);
        chk("pulse_width", {31'h0, rvalid[k]}, 32'h0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] d;
        logic [31:0] exp;
        int          first_n;
        int          pulses;

        arstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        #13;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rvalid", {31'h0, rvalid[k]}, 32'h0);
            chk("rst_rdata", rdata[k], 32'h0);
            chk("rst_err", {31'h0, err[k]}, 32'h0);
        end
        @(negedge clk);
        arstn = 1'b1;

        // Fill every word so later reads have defined contents; the first one is accepted on the first edge
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++)
                txn(k, 1'b1, 4'hF, base_of(k) + 32'(4 * i), $urandom, 1'b0, got);

        // Basic write then read at LATENCY 1
        txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, got);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, got);
        chk("basic_read", got, 32'hDEADBEEF);

        // Byte-enable merge
        txn(0, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0, got);
        txn(0, 1'b1, 4'b0100, 32'h20, 32'h00AB0000, 1'b0, got);
        txn(0, 1'b0, 4'h1, 32'h23, 32'h0, 1'b0, got);
        chk("be_merge", got, 32'hFFABFFFF);
        txn(0, 1'b1, 4'h0, 32'h20, 32'h12345678, 1'b0, got);
        txn(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, got);
        chk("be_zero_write", got, 32'hFFABFFFF);

        // LATENCY 3, request held for 6 cycles: one pulse at cycle 3, re-acceptance in the next IDLE cycle
        exp = model[1][2];
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h108; wdata[1] = 32'h0;
        @(posedge clk);
        first_n = 0; pulses = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (rvalid[1]) begin
                pulses++;
                if (first_n == 0) first_n = n;
            end
        end
        req[1] = 1'b0;
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_first_at", 32'(first_n), 32'd3);
        first_n = 0;
        for (int n = 7; n <= 9; n++) begin
            @(negedge clk);
            if (rvalid[1]) begin
                pulses++;
                if (first_n == 0) first_n = n;
                chk("hold_second_rdata", rdata[1], exp);
            end
        end
        chk("hold_second_at", 32'(first_n), 32'd7);
        chk("hold_total", 32'(pulses), 32'd2);

        // Out of range: one word past the end, and one word below the base
        txn(0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, got);
        exp = model[1][15];
        txn(1, 1'b1, 4'hF, 32'hFC, 32'hA5A5A5A5, 1'b0, got);
        txn(1, 1'b0, 4'hF, 32'h13C, 32'h0, 1'b0, got);
        chk("oor_write_dropped", got, exp);

        // Reset while the response is on the bus clears the outputs at once
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
        @(posedge clk);
        @(negedge clk);
        chk("resp_before_rst", {31'h0, rvalid[0]}, 32'h1);
        arstn = 1'b0;
        #1;
        chk("rst_resp_rvalid", {31'h0, rvalid[0]}, 32'h0);
        chk("rst_resp_rdata", rdata[0], 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        arstn = 1'b1;

        // Reset during WAIT at LATENCY 4: no later pulse, the accepted write persists
        d = $urandom;
        model[2][2] = merge(model[2][2], d, 4'b0011);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'b0011; addr[2] = 32'h108; wdata[2] = d;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b0;
        #1;
        chk("rst_wait_rvalid", {31'h0, rvalid[2]}, 32'h0);
        chk("rst_wait_rdata", rdata[2], 32'h0);
        chk("rst_wait_err", {31'h0, err[2]}, 32'h0);
        req[2] = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rvalid[2]) pulses++;
        end
        chk("rst_no_late_pulse", 32'(pulses), 32'd0);
        txn(2, 1'b0, 4'hF, 32'h108, 32'h0, 1'b0, got);

        // Back-to-back alternating write/read stream with request held high
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) txn(0, 1'b1, 4'hF, 32'(4 * i), $urandom, 1'b1, got);
            else            txn(0, 1'b0, 4'hF, 32'(4 * (i - 1)), 32'h0, (i != 7), got);
        end

        // Random traffic, including addresses just outside the window
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 25; i++)
                txn(k, 1'($urandom), 4'($urandom), base_of(k) - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 15)),
                    $urandom, (i != 24) && 1'($urandom), got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
